// File: rtl/bounds_check_sched.sv
// bounds_check_sched: arbitrates alloc/check requests and scans the base buffer one entry per cycle (optional BCS_STATS_EN adds response counters)
module bounds_check_sched #(
    parameter int SIZE   = 32,
    parameter int IDX_W  = $clog2(SIZE),
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic [ADDR_W-1:0] alloc_base_i,
    input  logic              chk_valid_i,
    output logic              chk_ready_o,
    input  logic [ADDR_W-1:0] chk_base_i,
    input  logic [ADDR_W-1:0] chk_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_overflow_o,
    output logic [ADDR_W-1:0] rsp_limit_o,
    output logic [IDX_W-1:0]  buf_rd_idx_o,
    input  logic [ADDR_W-1:0] buf_rd_data_i,
    output logic              buf_wr_en_o,
    output logic [ADDR_W-1:0] buf_wr_base_o,
    output logic              buf_clear_o
`ifdef BCS_STATS_EN
    ,
    output logic [31:0]       stat_chk_o,
    output logic [31:0]       stat_ovf_o
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;
    localparam logic [ADDR_W-1:0] ONES = '1;
    state_t state, state_n;
    logic [IDX_W-1:0] idx;
    logic [ADDR_W-1:0] base, addr, closest, closest_n;
    logic op_chk, dup, dup_n, prio_chk, clr_q;
    logic both, alloc_hs, chk_hs, last, hit;
    // grant, scan compare and next-state; readies forced low during reset and clear
    always_comb begin
        both          = alloc_valid_i && chk_valid_i;
        alloc_ready_o = !rst_i && state == IDLE && !clear_i && !(both && prio_chk);
        chk_ready_o   = !rst_i && state == IDLE && !clear_i && !(both && !prio_chk);
        alloc_hs      = alloc_valid_i && alloc_ready_o;
        chk_hs        = chk_valid_i && chk_ready_o;
        hit           = buf_rd_data_i != '0;
        last          = idx == IDX_W'(SIZE - 1);
        closest_n     = (hit && buf_rd_data_i > base && buf_rd_data_i < closest) ? buf_rd_data_i : closest;
        dup_n         = dup || (hit && buf_rd_data_i == base);
        state_n       = state;
        case (state)
            IDLE:    state_n = (alloc_hs || chk_hs) ? SCAN : IDLE;
            SCAN:    state_n = !last ? SCAN : op_chk ? RESP : (!dup_n && base != '0) ? WRITE : IDLE;
            WRITE:   state_n = IDLE;
            default: state_n = rsp_ready_i ? IDLE : RESP;
        endcase
        if (clear_i) state_n = IDLE;
        rsp_valid_o    = state == RESP;
        rsp_limit_o    = rsp_valid_o ? closest : '0;
        rsp_overflow_o = rsp_valid_o && closest != ONES && addr >= closest;
        buf_rd_idx_o   = state == SCAN ? idx : '0;
        buf_wr_en_o    = state == WRITE;
        buf_wr_base_o  = buf_wr_en_o ? base : '0;
        buf_clear_o    = clr_q;
    end
    // operand latch on handshake, per-entry scan accumulation, round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            base     <= '0;
            addr     <= '0;
            closest  <= '0;
            op_chk   <= 1'b0;
            dup      <= 1'b0;
            prio_chk <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state <= state_n;
            clr_q <= clear_i;
            if (alloc_hs || chk_hs) begin
                op_chk   <= chk_hs;
                base     <= chk_hs ? chk_base_i : alloc_base_i;
                addr     <= chk_addr_i;
                closest  <= ONES;
                dup      <= 1'b0;
                idx      <= '0;
                prio_chk <= alloc_hs;
            end else if (state == SCAN) begin
                closest <= closest_n;
                dup     <= dup_n;
                if (!last) idx <= idx + IDX_W'(1);
            end
        end
    end
`ifdef BCS_STATS_EN
    logic done;
    assign done = rsp_valid_o && rsp_ready_i && !clear_i;
    // saturating counts of completed responses and overflowing responses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_chk_o <= '0;
            stat_ovf_o <= '0;
        end else if (clear_i) begin
            stat_chk_o <= '0;
            stat_ovf_o <= '0;
        end else if (done) begin
            if (stat_chk_o != '1) stat_chk_o <= stat_chk_o + 32'd1;
            if (rsp_overflow_o && stat_ovf_o != '1) stat_ovf_o <= stat_ovf_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bounds_check_sched.sv
// tb_bounds_check_sched: directed vector table plus handshake, arbitration and clear sequences with SIZE=4
module tb_bounds_check_sched;
    logic clk_i = 1'b0, rst_i = 1'b1, clear_i = 1'b0;
    logic alloc_valid_i = 1'b0, chk_valid_i = 1'b0, rsp_ready_i = 1'b0;
    logic [31:0] alloc_base_i = '0, chk_base_i = '0, chk_addr_i = '0;
    logic alloc_ready_o, chk_ready_o, rsp_valid_o, rsp_overflow_o, buf_wr_en_o, buf_clear_o;
    logic [31:0] rsp_limit_o, buf_rd_data_i, buf_wr_base_o;
    logic [1:0] buf_rd_idx_o;
`ifdef BCS_STATS_EN
    logic [31:0] stat_chk_o, stat_ovf_o;
`endif
    logic [3:0][31:0] mem = '0, pre_val = '0;
    logic pre_req = 1'b0;
    logic [1:0] cur = '0;
    int n_vec = 0, n_err = 0;

    typedef struct {
        logic is_chk;
        logic [31:0] base, addr;
        logic [3:0][31:0] bufv;
        logic [31:0] exp_limit;
        logic exp_ovf, exp_wr;
    } vec_t;
    vec_t vecs[12];

    bounds_check_sched #(.SIZE(4), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_base_i(alloc_base_i),
        .chk_valid_i(chk_valid_i), .chk_ready_o(chk_ready_o), .chk_base_i(chk_base_i), .chk_addr_i(chk_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_overflow_o(rsp_overflow_o), .rsp_limit_o(rsp_limit_o),
        .buf_rd_idx_o(buf_rd_idx_o), .buf_rd_data_i(buf_rd_data_i), .buf_wr_en_o(buf_wr_en_o),
        .buf_wr_base_o(buf_wr_base_o), .buf_clear_o(buf_clear_o)
`ifdef BCS_STATS_EN
        , .stat_chk_o(stat_chk_o), .stat_ovf_o(stat_ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    assign buf_rd_data_i = mem[buf_rd_idx_o];

    // circular buffer model: preload, clear pulse, write at cursor
    always @(posedge clk_i) begin
        if (pre_req) begin
            mem <= pre_val;
            cur <= '0;
        end else if (buf_clear_o) begin
            mem <= '0;
            cur <= '0;
        end else if (buf_wr_en_o) begin
            mem[cur] <= buf_wr_base_o;
            cur <= cur + 2'd1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic [31:0] b, a, b0, b1, b2, b3, lim,
                                input logic ovf, wr);
        vec_t v;
        v.is_chk = c; v.base = b; v.addr = a;
        v.bufv[0] = b0; v.bufv[1] = b1; v.bufv[2] = b2; v.bufv[3] = b3;
        v.exp_limit = lim; v.exp_ovf = ovf; v.exp_wr = wr;
        return v;
    endfunction

    task automatic preload(input logic [3:0][31:0] val);
        @(negedge clk_i);
        pre_val = val;
        pre_req = 1'b1;
        @(negedge clk_i);
        pre_req = 1'b0;
    endtask

    task automatic issue(input logic c, input logic [31:0] b, input logic [31:0] a, input string name);
        int n = 0;
        @(negedge clk_i);
        if (c) begin
            chk_valid_i = 1'b1; chk_base_i = b; chk_addr_i = a;
        end else begin
            alloc_valid_i = 1'b1; alloc_base_i = b;
        end
        #1;
        while (!(c ? chk_ready_o : alloc_ready_o) && n < 20) begin
            @(negedge clk_i); #1; n++;
        end
        cmp({name, " accept"}, 32'(n < 20), 32'd1);
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        chk_valid_i = 1'b0;
    endtask

    task automatic wait_evt(output int lat);
        lat = 1;
        while (!(rsp_valid_o || buf_wr_en_o || alloc_ready_o) && lat < 12) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        int lat;
        preload(v.bufv);
        issue(v.is_chk, v.base, v.addr, name);
        wait_evt(lat);
        cmp({name, " latency"}, lat, 5);
        cmp({name, " rsp_valid"}, 32'(rsp_valid_o), 32'(v.is_chk));
        cmp({name, " wr_en"}, 32'(buf_wr_en_o), 32'(v.exp_wr));
        if (v.is_chk) begin
            cmp({name, " limit"}, rsp_limit_o, v.exp_limit);
            cmp({name, " overflow"}, 32'(rsp_overflow_o), 32'(v.exp_ovf));
        end
        if (v.exp_wr) cmp({name, " wr_base"}, buf_wr_base_o, v.base);
        rsp_ready_i = rsp_valid_o;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        #1;
        cmp({name, " idle"}, 32'(alloc_ready_o), 32'd1);
    endtask

    initial begin
        int lat, n, clr_cnt;
        logic seen_rsp, seen_wr, exp_alloc;
        vecs[0]  = mk(1, 32'h100, 32'h1F0, 32'h100, 32'h200, 0, 0, 32'h200, 0, 0);
        vecs[1]  = mk(1, 32'h100, 32'h200, 32'h100, 32'h200, 0, 0, 32'h200, 1, 0);
        vecs[2]  = mk(1, 32'h100, 32'hFFFF, 32'h100, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        vecs[3]  = mk(1, 32'h100, 32'h260, 32'h300, 32'h150, 0, 32'h250, 32'h150, 1, 0);
        vecs[4]  = mk(1, 32'h9000_0000, 32'h9FFF_FFFF, 32'h8000_0000, 32'hA000_0000, 32'hFFFF_FFF0, 0, 32'hA000_0000, 0, 0);
        vecs[5]  = mk(1, 32'h100, 32'h17F, 0, 0, 0, 32'h180, 32'h180, 0, 0);
        vecs[6]  = mk(1, 32'h100, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
        vecs[7]  = mk(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 32'h300, 0, 32'h300, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 32'h500, 0, 0, 0, 0, 32'h500, 0, 0, 0);
        vecs[11] = mk(0, 32'h400, 0, 32'h100, 32'h200, 32'h300, 0, 0, 0, 1);

        @(negedge clk_i); #1;
        cmp("reset alloc_ready", 32'(alloc_ready_o), 0);
        cmp("reset chk_ready", 32'(chk_ready_o), 0);
        cmp("reset rsp_valid", 32'(rsp_valid_o), 0);
        cmp("reset wr_en", 32'(buf_wr_en_o), 0);
        cmp("reset clear", 32'(buf_clear_o), 0);
        cmp("reset limit", rsp_limit_o, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("vec%0d", i));
`ifdef BCS_STATS_EN
        cmp("stat_chk after table", stat_chk_o, 7);
        cmp("stat_ovf after table", stat_ovf_o, 2);
`endif

        preload({32'h0, 32'h0, 32'h200, 32'h100});
        issue(1'b1, 32'h100, 32'h200, "hold");
        wait_evt(lat);
        cmp("hold latency", lat, 5);
        for (int i = 0; i < 3; i++) begin
            cmp("hold rsp_valid", 32'(rsp_valid_o), 1);
            cmp("hold limit", rsp_limit_o, 32'h200);
            cmp("hold overflow", 32'(rsp_overflow_o), 1);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        cmp("hold release", 32'(rsp_valid_o), 0);

        rst_i = 1'b1;
        alloc_valid_i = 1'b1; alloc_base_i = 32'h700;
        chk_valid_i = 1'b1; chk_base_i = 32'h100; chk_addr_i = 32'h0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        for (int g = 0; g < 4; g++) begin
            exp_alloc = (g % 2) == 0;
            n = 0;
            #1;
            while (!(alloc_ready_o || chk_ready_o) && n < 20) begin
                @(negedge clk_i); #1; n++;
            end
            cmp($sformatf("rr grant%0d found", g), 32'(n < 20), 1);
            cmp($sformatf("rr grant%0d alloc_ready", g), 32'(alloc_ready_o), 32'(exp_alloc));
            cmp($sformatf("rr grant%0d chk_ready", g), 32'(chk_ready_o), 32'(!exp_alloc));
            @(negedge clk_i);
        end
        alloc_valid_i = 1'b0;
        chk_valid_i = 1'b0;
        repeat (8) @(negedge clk_i);
        rsp_ready_i = 1'b0;

        preload({32'h0, 32'h0, 32'h200, 32'h100});
        issue(1'b1, 32'h100, 32'h300, "clear");
        @(negedge clk_i); @(negedge clk_i);
        cmp("clear scan idx", 32'(buf_rd_idx_o), 2);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        cmp("clear pulse", 32'(buf_clear_o), 1);
        cmp("clear alloc_ready after", 32'(alloc_ready_o), 1);
        cmp("clear chk_ready after", 32'(chk_ready_o), 1);
        seen_rsp = 1'b0; seen_wr = 1'b0; clr_cnt = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            seen_rsp |= rsp_valid_o;
            seen_wr |= buf_wr_en_o;
            clr_cnt += int'(buf_clear_o);
        end
        cmp("clear no rsp", 32'(seen_rsp), 0);
        cmp("clear no write", 32'(seen_wr), 0);
        cmp("clear single pulse", clr_cnt, 1);
        alloc_valid_i = 1'b1; alloc_base_i = 32'h900;
        clear_i = 1'b1;
        #1;
        cmp("clear blocks alloc_ready", 32'(alloc_ready_o), 0);
        cmp("clear blocks chk_ready", 32'(chk_ready_o), 0);
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        clear_i = 1'b0;
        #1;
        cmp("clear idle pulse", 32'(buf_clear_o), 1);
        cmp("clear idle no scan", 32'(alloc_ready_o), 1);
`ifdef BCS_STATS_EN
        cmp("stat_chk cleared", stat_chk_o, 0);
        cmp("stat_ovf cleared", stat_ovf_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bounds_check_sched.md
Name: bounds_check_sched

Overview:
- Sequencer and arbiter in front of the base-address circular buffer used for buffer-overflow detection.
- Serves two requesters through one shared buffer port pair:
  - allocation unit: records new block base addresses, with duplicate suppression.
  - LSU checker: asks whether an access address runs past the next higher recorded base.
- Scans the buffer one entry per cycle through its read port, so the buffer needs no SIZE-wide comparator tree.

Parameters:
- SIZE, 32, number of buffer entries; power of two, at least 2.
- IDX_W, $clog2(SIZE), width of the buffer index.
- ADDR_W, 32, address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous clear (debug instruction)
- alloc_valid_i  in  1  allocation request
- alloc_ready_o  out  1  allocation accepted this cycle when valid is high
- alloc_base_i  in  ADDR_W  base address to record
- chk_valid_i  in  1  check request
- chk_ready_o  out  1  check accepted this cycle when valid is high
- chk_base_i  in  ADDR_W  base of the block being accessed
- chk_addr_i  in  ADDR_W  access address
- rsp_valid_o  out  1  check result valid
- rsp_ready_i  in  1  result consumed
- rsp_overflow_o  out  1  access address is at or past the limit
- rsp_limit_o  out  ADDR_W  closest recorded base above chk_base; all-ones if none
- buf_rd_idx_o  out  IDX_W  buffer read index
- buf_rd_data_i  in  ADDR_W  buffer entry at buf_rd_idx_o, combinational, same cycle
- buf_wr_en_o  out  1  one-cycle write pulse; the buffer stores the value at its cursor
- buf_wr_base_o  out  ADDR_W  value to write
- buf_clear_o  out  1  one-cycle buffer clear pulse

Behaviour:
- Reset (async, rst_i=1): state IDLE, every output 0, priority pointer set to favour alloc.
- States: IDLE, SCAN, WRITE, RESP. One operation in flight at a time.
- IDLE:
  - alloc_ready_o and chk_ready_o are high unless clear_i is high.
  - If both requests are valid, grant alternates between them (round-robin). Only the granted ready is high in that cycle.
  - Handshake = valid && ready. On handshake, latch the operands, set op type, idx=0, go to SCAN.
- SCAN:
  - Runs SIZE cycles with buf_rd_idx_o = idx.
  - Entries equal to 0 are empty and are ignored.
  - Check op: closest starts at all-ones; if entry > base and entry < closest, closest = entry.
  - Alloc op: dup is set if entry == base.
  - After idx = SIZE-1: check goes to RESP; alloc goes to WRITE if !dup and base != 0, otherwise to IDLE.
  - idx does not wrap. All comparisons are unsigned.
- WRITE:
  - buf_wr_en_o = 1 and buf_wr_base_o = base for exactly one cycle, then IDLE.
- RESP:
  - rsp_valid_o is held high, with limit and overflow stable, until rsp_ready_i is high.
  - rsp_overflow_o = (closest != all-ones) && (addr >= closest).
  - Then IDLE.
- Latency: accept at cycle T; response valid or write pulse at T+SIZE+1; earliest next accept at T+SIZE+2 (T+SIZE+1 for a duplicate or zero alloc).
- clear_i:
  - Overrides everything: buf_clear_o pulses on the following cycle, state goes to IDLE, and any pending response or write is dropped.
  - Readies are low during the clear_i cycle.
- Reset mid-operation aborts the operation with no write and no response.
- rsp_valid_o never drops without rsp_ready_i, except on clear or reset.

Optional Feature:
- BCS_STATS_EN defined:
  - Adds outputs stat_chk_o[31:0] (responses completed) and stat_ovf_o[31:0] (responses with overflow=1).
  - Both counters saturate at all-ones and reset to 0 on rst_i or clear_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan (SIZE=4):
- Buffer {0x100,0x200,0,0}; check base=0x100, addr=0x1F0 -> rsp at T+5, limit=0x200, overflow=0.
- Same buffer; check base=0x100, addr=0x200 -> overflow=1, limit=0x200; hold rsp_ready_i low 3 cycles -> rsp_valid_o and data stable throughout.
- Buffer {0x100,0,0,0}; check base=0x100, addr=0xFFFF -> limit=0xFFFFFFFF, overflow=0.
- Alloc 0x300 into empty buffer -> buf_wr_en_o pulse at T+5 with 0x300; alloc 0x300 again -> no pulse, ready again at T+5; alloc 0 -> no pulse.
- alloc_valid_i and chk_valid_i held together from reset -> grants alternate alloc, chk, alloc, chk; neither requester starves.
- clear_i during SCAN at idx=2 -> buf_clear_o pulses once, no response or write, readies high in the following cycle; with BCS_STATS_EN, counters read 0.
